fp_alu_sched: RTL and testbench

FP_ALU_SCHED -- requirements
Module: fp_alu_sched

---
 rtl/fp_alu_sched.sv | 154 +++++++++++++++
 tb/tb_fp_alu_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_sched.sv
// Two-requester round-robin front end for a fixed-latency fp_alu, one operation in flight.
// Optional feature: define FP_ALU_SCHED_PERF_EN to enable the saturating op_count counter.
module fp_alu_sched #(
  parameter int ALU_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic [31:0] alu_num1,
  output logic [31:0] alu_num2,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_s,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam logic [3:0] LAT = 4'(ALU_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] num1_q, num1_d;
  logic [31:0] num2_q, num2_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] res_q, res_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        gnt;
  logic        rsp_hs;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    num1_d     = num1_q;
    num2_d     = num2_q;
    op_d       = op_q;
    res_d      = res_q;
    owner_d    = owner_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_hs     = 1'b0;
    // On a tie the requester not served last wins; a lone requester always wins.
    gnt        = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    case (state_q)
      S_IDLE: begin
        // Gated by rstn so a request is never acknowledged on a reset edge.
        req0_ready = rstn & req0_valid & ~gnt;
        req1_ready = rstn & req1_valid & gnt;
        if (req0_ready || req1_ready) begin
          num1_d  = gnt ? req1_a  : req0_a;
          num2_d  = gnt ? req1_b  : req0_b;
          op_d    = gnt ? req1_op : req0_op;
          owner_d = gnt;
          last_d  = gnt;
          cnt_d   = LAT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          res_d   = alu_s;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        rsp_hs     = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
        if (rsp_hs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      num1_q  <= 32'd0;
      num2_q  <= 32'd0;
      op_q    <= 2'd0;
      res_q   <= 32'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      op_q    <= op_d;
      res_q   <= res_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign alu_num1  = num1_q;
  assign alu_num2  = num2_q;
  assign alu_op    = op_q;
  assign rsp0_data = res_q;
  assign rsp1_data = res_q;
  assign busy      = (state_q != S_IDLE);

`ifdef FP_ALU_SCHED_PERF_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (rsp_hs && (op_count_q != 16'hFFFF)) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_count_q <= 16'd0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`else
  assign op_count = 16'd0;
`endif

endmodule

// File: tb/tb_fp_alu_sched.sv
// Directed bench for fp_alu_sched: transaction-level expectation model plus literal checks.
`timescale 1ns/1ps
module tb_fp_alu_sched;

  localparam int L = 3;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } req_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req1_valid = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1;
  logic        rsp1_ready = 1'b1;
  logic [31:0] rsp0_data, rsp1_data;
  logic [31:0] alu_num1, alu_num2;
  logic [1:0]  alu_op;
  logic [31:0] alu_s = 32'hDEADBEEF;
  logic        busy;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  fp_alu_sched #(.ALU_LATENCY(L)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op), .alu_s(alu_s),
    .busy(busy), .op_count(op_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in fp_alu result function; any deterministic mix of the operands will do.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    return (a ^ {b[15:0], b[31:16]}) + {30'd0, op};
  endfunction

  // Stand-in ALU: result becomes correct only after L cycles of stable inputs.
  logic [65:0] alu_prev = '0;
  int stab = 0;
  always @(negedge clk) begin
    if ({alu_num1, alu_num2, alu_op} === alu_prev) stab++;
    else begin
      stab = 1;
      alu_prev = {alu_num1, alu_num2, alu_op};
    end
    alu_s = (stab >= L) ? alu_f(alu_num1, alu_num2, alu_op) : 32'hDEADBEEF;
  end

  // Requester drivers: hold valid until the handshake, then present the next queued item.
  req_t q0[$], q1[$];
  logic hs0 = 1'b0, hs1 = 1'b0;
  req_t r0, r1;

  always begin
    @(negedge clk);
    hs0 = req0_valid & req0_ready;
    @(posedge clk);
    #1;
    if (hs0 || !req0_valid) begin
      if (q0.size() != 0) begin
        r0 = q0.pop_front();
        req0_valid = 1'b1; req0_a = r0.a; req0_b = r0.b; req0_op = r0.op;
      end else begin
        req0_valid = 1'b0;
      end
    end
  end

  always begin
    @(negedge clk);
    hs1 = req1_valid & req1_ready;
    @(posedge clk);
    #1;
    if (hs1 || !req1_valid) begin
      if (q1.size() != 0) begin
        r1 = q1.pop_front();
        req1_valid = 1'b1; req1_a = r1.a; req1_b = r1.b; req1_op = r1.op;
      end else begin
        req1_valid = 1'b0;
      end
    end
  end

  function automatic req_t mk(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    req_t r;
    r.a = a; r.b = b; r.op = op;
    return r;
  endfunction

  // Transaction model: one job at a time, result visible from L+1 cycles after acceptance.
  int          cyc = 0;
  int          tacc = 0;
  int          ndone = 0;
  logic        pend = 1'b0;
  logic        own = 1'b0;
  logic        last = 1'b1;
  logic [31:0] m_n1 = '0, m_n2 = '0;
  logic [1:0]  m_op = '0;
  logic [15:0] mcnt = '0;

  always @(posedge clk) begin
    if (!rstn) begin
      pend = 1'b0; last = 1'b1; m_n1 = '0; m_n2 = '0; m_op = '0; mcnt = '0;
    end else if (!pend) begin
      if (req0_valid || req1_valid) begin
        if (req0_valid && !req1_valid) own = 1'b0;
        else if (req1_valid && !req0_valid) own = 1'b1;
        else own = (last == 1'b0);
        m_n1 = own ? req1_a : req0_a;
        m_n2 = own ? req1_b : req0_b;
        m_op = own ? req1_op : req0_op;
        last = own;
        pend = 1'b1;
        tacc = cyc;
      end
    end else if (cyc - tacc > L) begin
      if ((!own && rsp0_ready) || (own && rsp1_ready)) begin
        pend = 1'b0;
        ndone++;
        if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      end
    end
    cyc++;
  end

  // Per-cycle compare against the model, plus DUT-side observation logs for literal checks.
  logic        chk_en = 1'b0;
  logic        rv;
  logic [15:0] exp_opc;
  int          served_d[$];
  int          ncyc = 0;
  int          hs_n = -100;
  int          rise0 = -100;
  int          rvcnt = 0;
  logic        prev_rv0 = 1'b0;
  logic [31:0] snap_n1 = '0, snap_n2 = '0, rise_data = '0;
  logic [1:0]  snap_op = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      rv = pend && (cyc - tacc > L);
`ifdef FP_ALU_SCHED_PERF_EN
      exp_opc = mcnt;
`else
      exp_opc = 16'd0;
`endif
      chk("req0_ready", 32'(req0_ready),
          32'(rstn && !pend && req0_valid && (!req1_valid || last)));
      chk("req1_ready", 32'(req1_ready),
          32'(rstn && !pend && req1_valid && (!req0_valid || !last)));
      chk("busy", 32'(busy), 32'(pend));
      chk("rsp0_valid", 32'(rsp0_valid), 32'(rv && !own));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(rv && own));
      if (rv) begin
        chk("rsp0_data", rsp0_data, alu_f(m_n1, m_n2, m_op));
        chk("rsp1_data", rsp1_data, alu_f(m_n1, m_n2, m_op));
      end
      chk("alu_num1", alu_num1, m_n1);
      chk("alu_num2", alu_num2, m_n2);
      chk("alu_op", 32'(alu_op), 32'(m_op));
      chk("op_count", 32'(op_count), 32'(exp_opc));
    end
    if (req0_valid && req0_ready) begin served_d.push_back(0); hs_n = ncyc; end
    if (req1_valid && req1_ready) served_d.push_back(1);
    if (ncyc == hs_n + 1) begin snap_n1 = alu_num1; snap_n2 = alu_num2; snap_op = alu_op; end
    if (rsp0_valid && !prev_rv0) begin rise0 = ncyc; rise_data = rsp0_data; end
    if (rsp0_valid || rsp1_valid) rvcnt++;
    prev_rv0 = rsp0_valid;
    ncyc++;
  end

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (ndone < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (ndone < target) begin
      failures++;
      $display("FAIL %s timeout: done=%0d expected %0d", name, ndone, target);
    end
  endtask

  int   n;
  int   stable;
  logic [31:0] d0;
  int   exp_order[$];

  initial begin
    // Reset and reset values
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_num1", alu_num1, 32'd0);
    chk("rst_rsp0_data", rsp0_data, 32'd0);
    chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Tie from reset: req0 first, then req1
    q0.push_back(mk(32'h40490FDB, 32'h3F800000, 2'b00));
    q1.push_back(mk(32'hC0200000, 32'h41200000, 2'b10));
    wait_done(2, "tie1");

    // Lone req0 directed vector
    q0.push_back(mk(32'h3F8E147B, 32'h3F8147AE, 2'b01));
    wait_done(3, "lone0");
    chk("lone0_op", 32'(snap_op), 32'h1);
    chk("lone0_num1", snap_n1, 32'h3F8E147B);
    chk("lone0_num2", snap_n2, 32'h3F8147AE);
    chk("lone0_latency", 32'(rise0 - hs_n), 32'(L + 1));
    chk("lone0_data", rise_data, 32'h78202BFB);
`ifdef FP_ALU_SCHED_PERF_EN
    chk("op_count_3", 32'(op_count), 32'd3);
`else
    chk("op_count_off", 32'(op_count), 32'd0);
`endif

    // Lone req1, then a tie must go to req0
    q1.push_back(mk(32'h12345678, 32'h9ABCDEF0, 2'b11));
    wait_done(4, "lone1");
    q0.push_back(mk(32'h00000001, 32'h00000002, 2'b01));
    q1.push_back(mk(32'hFFFFFFFF, 32'h80000000, 2'b10));
    wait_done(6, "tie2");

    // Response backpressure on req1 with req0 pending
    rsp1_ready = 1'b0;
    q1.push_back(mk(32'h42C80000, 32'h3DCCCCCD, 2'b10));
    n = 0;
    while (!rsp1_valid && n < 50) begin @(negedge clk); n++; end
    chk("stall_valid_seen", 32'(rsp1_valid), 32'd1);
    d0 = rsp1_data;
    q0.push_back(mk(32'h0F0F0F0F, 32'hF0F0F0F0, 2'b00));
    stable = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp1_valid && rsp1_data === d0 && !req0_ready && !req1_ready && busy) stable++;
    end
    chk("stall_stable", 32'(stable), 32'd5);
    @(posedge clk); #1;
    rsp1_ready = 1'b1;
    wait_done(8, "stall");

    exp_order = '{0, 1, 0, 1, 0, 1, 1, 0};
    chk("order_len", 32'(served_d.size()), 32'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < served_d.size(); i++)
      chk($sformatf("order_%0d", i), 32'(served_d[i]), 32'(exp_order[i]));

    // Reset in the middle of WAIT aborts the job
    q0.push_back(mk(32'h11111111, 32'h22222222, 2'b11));
    n = 0;
    while (!busy && n < 50) begin @(negedge clk); n++; end
    chk("abort_busy_seen", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_num1", alu_num1, 32'd0);
    chk("abort_op", 32'(alu_op), 32'd0);
    chk("abort_data", rsp0_data, 32'd0);
    chk("abort_opc", 32'(op_count), 32'd0);
    rvcnt = 0;
    repeat (L + 4) @(negedge clk);
    chk("abort_no_rsp", 32'(rvcnt), 32'd0);
    q0.push_back(mk(32'h3C000000, 32'h3E000000, 2'b01));
    wait_done(9, "after_abort");
    chk("after_abort_rsp", 32'(rvcnt), 32'd1);

`ifdef FP_ALU_SCHED_PERF_EN
    // Saturation of the performance counter
    @(posedge clk); #1;
    dut.op_count_q = 16'hFFFF;
    mcnt = 16'hFFFF;
    q1.push_back(mk(32'h55555555, 32'hAAAAAAAA, 2'b01));
    wait_done(10, "sat");
    chk("op_count_sat", 32'(op_count), 32'h0000FFFF);
`else
    chk("op_count_end", 32'(op_count), 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t limit 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
